bank_read_arbiter: RTL and testbench
====================================

Name: bank_read_arbiter

Overview:
- Shares BANK_COUNT single-read-port memory banks among NUM_REQ read requesters.
- Address space is low-order interleaved: global address bits [BANK_BITS-1:0] select the bank, and the upper bits form the bank-local address.
- Each bank has its own round-robin arbiter, so requesters that hit different banks are served in the same cycle.
- Sits between the lane/load units and the bank array and steers each bank's registered read data back to the requester that owns it.

Parameters:
- ADDR_WIDTH, 10, bank-local address width.
- DATA_WIDTH, 64, bank word width.
- BANK_COUNT, 4, number of banks; must be a power of two, at least 2.
- NUM_REQ, 4, number of requesters, at least 2.
- BANK_BITS, $clog2(BANK_COUNT), derived; must not be overridden.
- GADDR_WIDTH, ADDR_WIDTH+BANK_BITS, derived global address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*GADDR_WIDTH  global address; requester r occupies slice [r*GADDR_WIDTH +: GADDR_WIDTH].
- req_ready  out  NUM_REQ  request accepted this cycle (combinational).
- resp_valid  out  NUM_REQ  read data valid.
- resp_data  out  NUM_REQ*DATA_WIDTH  read data, one slice per requester.
- bank_rd_addr  out  BANK_COUNT*ADDR_WIDTH  local address to each bank.
- bank_rd_data  in  BANK_COUNT*DATA_WIDTH  registered bank outputs (1-cycle read latency).

Behaviour:
- Target bank of requester r: b(r) = req_addr_r[BANK_BITS-1:0]. Local address = req_addr_r[GADDR_WIDTH-1:BANK_BITS].
- Per bank b, candidates are the requesters with req_valid=1 and b(r)=b.
- Grant goes to the first candidate at or after rr_ptr[b], searching upward modulo NUM_REQ.
- req_ready[r] = 1 iff r is granted by its target bank. It is purely combinational from req_valid, req_addr and rr_ptr, and has no dependency on resp_*.
- Each requester is granted by at most one bank per cycle.
- Acceptance (req_valid & req_ready) in cycle N:
  - bank_rd_addr[b] is driven combinationally with the granted local address in cycle N.
  - The bank samples it at the N→N+1 edge.
  - bank_rd_data[b] is sampled by this block at the N+1→N+2 edge.
  - resp_valid[r]=1 and resp_data[r]=that word in cycle N+2, registered.
  - Total request-to-response latency is 2 cycles, fully pipelined: one accept per requester per cycle.
- Per-requester pipeline: stage1 holds {valid, bank index} registered at acceptance; stage2 registers resp_valid/resp_data from bank_rd_data[stage1 bank].
- With no acceptance, resp_valid[r]=0 in the corresponding cycle, and resp_data holds its last value.
- rr_ptr[b] updates to (granted+1) mod NUM_REQ on a grant and holds when bank b is idle.
- Idle bank: bank_rd_addr[b] holds its last registered granted address (a shadow register), not zero, to avoid needless toggling.
- Losers keep req_valid asserted and retry; the address must stay stable while req_valid=1 and req_ready=0.
- Starvation bound: a continuously waiting requester is granted within NUM_REQ-1 grants of its bank.
- Reset (asynchronous, active-low):
  - rr_ptr=0, stage valids=0, resp_valid=0, resp_data=0, shadow bank addresses=0.
  - Reset mid-flight discards outstanding responses; no response is emitted after reset deassertion for a request accepted before reset.
- No write path. Bank writes are owned by a separate block; read-after-write ordering is the caller's responsibility.

Optional Feature:
- Macro: BANK_ARB_FIXED_PRIO_EN.
- Defined: each bank grants the lowest-index candidate (requester 0 has highest priority), and rr_ptr registers are not instantiated.
- Undefined: round-robin arbitration as above.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- Reset, then requesters 0-3 issue addresses 0,1,2,3 (all banks distinct) in the same cycle → all req_ready=1; two cycles later resp_valid=4'b1111 with resp_data = 0,1,2,3 (banks are initialised so word = global address).
- Requesters 0 and 2 both request bank 1 (addresses 5 and 9), held continuously → cycle N grants r0; N+1 grants r2 (rr_ptr=1); responses 5 at N+2 and 9 at N+3; with BANK_ARB_FIXED_PRIO_EN defined, r0 wins N and N+1 while r0 keeps requesting.
- All 4 requesters stream to bank 0 continuously for 16 cycles → each is granted exactly 4 times; grant order is 0,1,2,3,0,…; no requester waits more than 3 cycles.
- Requester 1 streams addresses 0..63 with req_valid always high and no conflicts → 64 consecutive resp_valid cycles, resp_data = 0..63 in order, starting 2 cycles after the first accept.
- Assert rst low one cycle after accepting address 7 for requester 3 → resp_valid stays 0 through and after reset; rr_ptr returns to 0, and the next contended grant goes to the lowest-index contender.
- A bank idle for 10 cycles after a grant with local address 0x12 → bank_rd_addr for that bank holds 0x12 the whole time.

Source files
------------

// File: rtl/bank_read_arbiter_if.sv
// Requester-side read bus of the bank read arbiter: request handshake plus registered responses.
interface bank_read_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned GADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH  = 64
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*GADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0]  resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/bank_read_arbiter.sv
// Per-bank arbitration of NUM_REQ readers onto BANK_COUNT low-order interleaved banks, 2-cycle latency.
// Define BANK_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module bank_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BANK_COUNT = 4,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  bank_read_arbiter_if.slave               req_if,
  output logic [BANK_COUNT*ADDR_WIDTH-1:0] bank_rd_addr,
  input  logic [BANK_COUNT*DATA_WIDTH-1:0] bank_rd_data
);

  localparam int unsigned BANK_BITS   = $clog2(BANK_COUNT);
  localparam int unsigned GADDR_WIDTH = ADDR_WIDTH + BANK_BITS;
  localparam int unsigned RR_W        = $clog2(NUM_REQ);

  logic [BANK_BITS-1:0]  req_bank  [NUM_REQ];
  logic [ADDR_WIDTH-1:0] req_local [NUM_REQ];

  logic                  grant_any [BANK_COUNT];
  logic [RR_W-1:0]       grant_idx [BANK_COUNT];
  logic [NUM_REQ-1:0]    ready_c;

  logic [ADDR_WIDTH-1:0] shadow_addr [BANK_COUNT];

  logic [NUM_REQ-1:0]    s1_valid;
  logic [BANK_BITS-1:0]  s1_bank [NUM_REQ];
  logic [NUM_REQ-1:0]    resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_data_q [NUM_REQ];

`ifndef BANK_ARB_FIXED_PRIO_EN
  logic [RR_W-1:0]       rr_ptr [BANK_COUNT];
`endif

  // Split each global address into bank select (low bits) and bank-local address.
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      req_bank[r]  = req_if.req_addr[r*GADDR_WIDTH +: BANK_BITS];
      req_local[r] = req_if.req_addr[r*GADDR_WIDTH + BANK_BITS +: ADDR_WIDTH];
    end
  end

  // Per-bank search for the first candidate starting at the bank's priority pointer.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      grant_any[b] = 1'b0;
      grant_idx[b] = '0;
      found        = 1'b0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
`ifdef BANK_ARB_FIXED_PRIO_EN
        idx = off;
`else
        idx = 32'(rr_ptr[b]) + off;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
`endif
        if (!found && req_if.req_valid[idx] && (req_bank[idx] == BANK_BITS'(b))) begin
          found        = 1'b1;
          grant_any[b] = 1'b1;
          grant_idx[b] = RR_W'(idx);
        end
      end
    end
  end

  // A requester is ready only when its own target bank picked it.
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      ready_c[r] = grant_any[req_bank[r]] && (grant_idx[req_bank[r]] == RR_W'(r));
    end
  end

  // Idle banks keep the last granted address to avoid toggling the array inputs.
  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      bank_rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH] =
        grant_any[b] ? req_local[grant_idx[b]] : shadow_addr[b];
    end
  end

  assign req_if.req_ready  = ready_c;
  assign req_if.resp_valid = resp_valid_q;

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      req_if.resp_data[r*DATA_WIDTH +: DATA_WIDTH] = resp_data_q[r];
    end
  end

`ifndef BANK_ARB_FIXED_PRIO_EN
  // Pointer moves just past the winner so every waiting requester gets a turn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        rr_ptr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        if (grant_any[b]) begin
          rr_ptr[b] <= (32'(grant_idx[b]) == NUM_REQ - 1) ? '0 : RR_W'(grant_idx[b] + 1'b1);
        end
      end
    end
  end
`endif

  // Shadow addresses plus the two-stage per-requester response pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        shadow_addr[b] <= '0;
      end
      s1_valid     <= '0;
      resp_valid_q <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        s1_bank[r]     <= '0;
        resp_data_q[r] <= '0;
      end
    end else begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        if (grant_any[b]) begin
          shadow_addr[b] <= req_local[grant_idx[b]];
        end
      end
      s1_valid     <= ready_c;
      resp_valid_q <= s1_valid;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (ready_c[r]) begin
          s1_bank[r] <= req_bank[r];
        end
        if (s1_valid[r]) begin
          resp_data_q[r] <= bank_rd_data[s1_bank[r]*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_read_arbiter.sv
// Scoreboard bench for bank_read_arbiter: banks hold word = global address, responses checked by a monitor.
module tb_bank_read_arbiter;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned NB = 4;
  localparam int unsigned NR = 4;
  localparam int unsigned BB = 2;
  localparam int unsigned GW = AW + BB;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q [NR][$];
  logic [NR-1:0] last_ready;

  logic [NB*AW-1:0] bank_rd_addr;
  logic [NB*DW-1:0] bank_rd_data;

  bank_read_arbiter_if #(.NUM_REQ(NR), .GADDR_WIDTH(GW), .DATA_WIDTH(DW)) bus ();

  bank_read_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_COUNT(NB), .NUM_REQ(NR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_if       (bus.slave),
    .bank_rd_addr (bank_rd_addr),
    .bank_rd_data (bank_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank array model: registered read, stored word equals its global address.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      bank_rd_data[b*DW +: DW] <= DW'({bank_rd_addr[b*AW +: AW], BB'(b)});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a response is presented or due.
  always @(negedge clk) begin
    exp_t e;
    for (int r = 0; r < NR; r++) begin
      if (bus.resp_valid[r] === 1'b1) begin
        if (exp_q[r].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp req=%0d cyc=%0d actual=%0h expected=none", r, cyc,
                   bus.resp_data[r*DW +: DW]);
        end else begin
          e = exp_q[r].pop_front();
          check($sformatf("resp_data_r%0d", r), bus.resp_data[r*DW +: DW], e.data);
          check($sformatf("resp_cycle_r%0d", r), 64'(cyc), 64'(e.due));
        end
      end else if (exp_q[r].size() != 0 && exp_q[r][0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_resp req=%0d cyc=%0d actual=none expected=%0h", r, cyc,
                 exp_q[r][0].data);
        void'(exp_q[r].pop_front());
      end
    end
  end

  // One request cycle: drive, check req_ready mid-cycle, push expected responses.
  task automatic step(input logic [3:0] v, input int a0, input int a1, input int a2, input int a3,
                      input logic [3:0] er, input bit push = 1'b1);
    logic [GW-1:0] ad [NR];
    ad[0] = GW'(a0);
    ad[1] = GW'(a1);
    ad[2] = GW'(a2);
    ad[3] = GW'(a3);
    bus.req_valid = v;
    bus.req_addr  = {ad[3], ad[2], ad[1], ad[0]};
    @(negedge clk);
    last_ready = bus.req_ready;
    check("req_ready", 64'(bus.req_ready), 64'(er));
    for (int r = 0; r < NR; r++) begin
      if (push && er[r]) exp_q[r].push_back('{data: DW'(ad[r]), due: cyc + 2});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 0, 0, 0, 0, 4'b0000);
  endtask

  initial begin
    int cnt [NR];
    logic [3:0] exp3;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset_resp_data", 64'(bus.resp_data[3*DW +: DW]), 64'd0);
    check("reset_bank_addr", 64'(bank_rd_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Two requesters contending for bank 1.
`ifdef BANK_ARB_FIXED_PRIO_EN
    step(4'b0101, 5, 0, 9, 0, 4'b0001);
    step(4'b0101, 5, 0, 9, 0, 4'b0001);
    step(4'b0100, 0, 0, 9, 0, 4'b0100);
`else
    step(4'b0101, 5, 0, 9, 0, 4'b0001);
    step(4'b0101, 5, 0, 9, 0, 4'b0100);
    step(4'b0001, 5, 0, 0, 0, 4'b0001);
`endif
    idle(3);

    // All requesters stream into bank 0.
    for (int r = 0; r < NR; r++) cnt[r] = 0;
    for (int k = 0; k < 16; k++) begin
`ifdef BANK_ARB_FIXED_PRIO_EN
      exp3 = 4'b0001;
`else
      exp3 = 4'(1 << (k % 4));
`endif
      step(4'b1111, 0, 4, 8, 12, exp3);
      for (int r = 0; r < NR; r++) cnt[r] += int'(last_ready[r]);
    end
`ifdef BANK_ARB_FIXED_PRIO_EN
    check("grant_count_r0", 64'(cnt[0]), 64'd16);
    check("grant_count_r3", 64'(cnt[3]), 64'd0);
`else
    for (int r = 0; r < NR; r++) check($sformatf("grant_count_r%0d", r), 64'(cnt[r]), 64'd4);
`endif
    idle(3);

    // Distinct banks in one cycle.
    step(4'b1111, 0, 1, 2, 3, 4'b1111);
    idle(2);

    // Requester 1 streams 0..63 without conflicts.
    for (int i = 0; i < 64; i++) step(4'b0010, 0, i, 0, 0, 4'b0010);
    idle(3);

    // Bank 2 granted local 0x12 (global 0x4A), then idle.
    step(4'b0001, 32'h4A, 0, 0, 0, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      check("idle_bank_addr", 64'(bank_rd_addr[2*AW +: AW]), 64'h12);
      step(4'b0000, 0, 0, 0, 0, 4'b0000);
    end
    idle(2);

    // Reset one cycle after accepting address 7 for requester 3; its response must vanish.
    step(4'b1000, 0, 0, 0, 7, 4'b1000, 1'b0);
    bus.req_valid = '0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("resp_valid_in_reset", 64'(bus.resp_valid), 64'd0);
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("resp_valid_after_reset", 64'(bus.resp_valid), 64'd0);
      @(posedge clk);
    end
    #1;
    // Bank 1 pointer was left past requester 1; after reset the lowest contender wins.
    step(4'b1001, 1, 0, 0, 13, 4'b0001);
    idle(4);

    for (int r = 0; r < NR; r++) check($sformatf("queue_empty_r%0d", r), 64'(exp_q[r].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
